// File: rtl/shift_tx_ctrl.sv
//------------------------------------------------------------------------------
// shift_tx_ctrl : Sequences a universal shift register as a framed serial
//                 transmitter. Optional loopback check: LOOPBACK_CHECK_EN.
// Revision      : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_tx_ctrl #(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    output logic [1:0]       sr_mode,
    output logic             sr_si,
    output logic [WIDTH-1:0] sr_din,
    input  logic [WIDTH-1:0] sr_q,
    input  logic             sr_so_left,
    input  logic             sr_so_right,
    output logic             tx_bit,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             chk_err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              dir_q, dir_d;
    logic              w_last;
    logic              w_done;

    assign w_last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        dir_d     = dir_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        sr_mode   = 2'b00;
        sr_si     = FILL;
        sr_din    = '0;
        tx_valid  = 1'b0;
        tx_bit    = 1'b0;
        tx_last   = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    word_d  = req_data;
                    dir_d   = req_dir;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                sr_mode = 2'b11;
                sr_din  = word_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                // The bit on the outgoing end of the register is the one being offered.
                tx_bit   = dir_q ? sr_so_right : sr_so_left;
                tx_last  = w_last;
                if (tx_ready) begin
                    sr_mode = dir_q ? 2'b10 : 2'b01;
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LOOPBACK_CHECK_EN
    logic chk_pend_q;
    logic chk_err_q;

    // After a full frame every bit has been replaced by FILL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_pend_q <= 1'b0;
            chk_err_q  <= 1'b0;
        end else if (w_done) begin
            chk_pend_q <= 1'b1;
        end else if (chk_pend_q && state_q == S_IDLE) begin
            chk_pend_q <= 1'b0;
            if (sr_q != {WIDTH{FILL}}) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    logic w_unused_chk;
    assign w_unused_chk = ^{sr_q, w_done};
    assign chk_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_tx_ctrl.sv
//------------------------------------------------------------------------------
// tb_shift_tx_ctrl : Self-checking bench for shift_tx_ctrl with a behavioural
//                    shift register attached.
// Revision         : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_tx_ctrl;

    localparam int   W    = 8;
    localparam logic FILL = 1'b0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_data = '0;
    logic         req_dir = 1'b0;
    logic [1:0]   sr_mode;
    logic         sr_si;
    logic [W-1:0] sr_din;
    logic [W-1:0] sr_q;
    logic         tx_bit, tx_valid, tx_last, busy, chk_err;
    logic         tx_ready = 1'b1;

    logic [W-1:0] sr_reg = '0;
    logic         ovr_en = 1'b0;
    logic [W-1:0] ovr_val = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Behavioural universal shift register the controller drives.
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   sr_reg <= {sr_reg[W-2:0], sr_si};
            2'b10:   sr_reg <= {sr_si, sr_reg[W-1:1]};
            2'b11:   sr_reg <= sr_din;
            default: sr_reg <= sr_reg;
        endcase
    end

    assign sr_q = ovr_en ? ovr_val : sr_reg;

    shift_tx_ctrl #(.WIDTH(W), .FILL(FILL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_dir(req_dir),
        .sr_mode(sr_mode), .sr_si(sr_si), .sr_din(sr_din), .sr_q(sr_q),
        .sr_so_left(sr_q[W-1]), .sr_so_right(sr_q[0]),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .chk_err(chk_err)
    );

    typedef struct {
        string        name;
        logic [W-1:0] data;
        logic         dir;
        int           stall_after;
        int           stall_len;
        logic [W-1:0] exp_seq;   // transmission order, leftmost bit first
        int           exp_busy;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: MSB-first sends the word as written, LSB-first sends it mirrored.
    function automatic logic [W-1:0] model_seq(input logic [W-1:0] d, input logic dir);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = dir ? d[W-1-i] : d[i];
        return r;
    endfunction

    task automatic run_frame(input string name, input logic [W-1:0] data, input logic dir,
                             input int stall_after, input int stall_len,
                             input logic [W-1:0] exp_seq, input int exp_busy,
                             input int abort_after);
        int hs = 0, stalled = 0, cyc = 0, busy_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = data; req_dir = dir; tx_ready = 1'b1;
        #1 check({name, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = ~data; req_dir = ~dir;
        #1;
        check({name, ".load_mode"}, 32'(sr_mode), 32'd3);
        check({name, ".load_din"}, 32'(sr_din), 32'(data));
        check({name, ".load_rdy"}, 32'(req_ready), 32'd0);
        busy_cnt += 32'(busy);
        while (hs < W) begin
            @(posedge clk); #1;
            if (abort_after != 0 && hs == abort_after) begin
                #2 rst = 1'b1;
                #1;
                check({name, ".abort_valid"}, 32'(tx_valid), 32'd0);
                check({name, ".abort_busy"}, 32'(busy), 32'd0);
                check({name, ".abort_rdy"}, 32'(req_ready), 32'd1);
                check({name, ".abort_mode"}, 32'(sr_mode), 32'd0);
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            cyc++;
            if (cyc > 4 * W + 16) begin
                check({name, ".timeout"}, 32'd0, 32'd1);
                return;
            end
            tx_ready = !(hs == stall_after && stalled < stall_len);
            #1;
            busy_cnt += 32'(busy);
            check({name, ".valid"}, 32'(tx_valid), 32'd1);
            check({name, ".bit"}, 32'(tx_bit), 32'(exp_seq[W-1-hs]));
            if (tx_ready) begin
                check({name, ".mode"}, 32'(sr_mode), dir ? 32'd2 : 32'd1);
                check({name, ".last"}, 32'(tx_last), 32'(hs == W - 1));
                hs++;
            end else begin
                check({name, ".stall_mode"}, 32'(sr_mode), 32'd0);
                stalled++;
            end
        end
        @(posedge clk); #2;
        tx_ready = 1'b1;
        check({name, ".end_busy"}, 32'(busy), 32'd0);
        check({name, ".end_rdy"}, 32'(req_ready), 32'd1);
        check({name, ".end_valid"}, 32'(tx_valid), 32'd0);
        check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    logic exp_err;

    initial begin
        vecs[0] = '{"msb_1e", 8'h1E, 1'b0, 99, 0, 8'h1E, W + 1};
        vecs[1] = '{"lsb_1e", 8'h1E, 1'b1, 99, 0, 8'h78, W + 1};
        vecs[2] = '{"stall_a5", 8'hA5, 1'b0, 2, 3, 8'hA5, W + 4};
        vecs[3] = '{"lsb_c1", 8'hC1, 1'b1, 0, 1, 8'h83, W + 2};
`ifdef LOOPBACK_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        #3;
        check("rst_async_rdy", 32'(req_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        #1;
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_mode", 32'(sr_mode), 32'd0);
        check("rst_din", 32'(sr_din), 32'd0);
        check("rst_si", 32'(sr_si), 32'(FILL));
        check("rst_chk", 32'(chk_err), 32'd0);

        for (int v = 0; v < 4; v++)
            run_frame(vecs[v].name, vecs[v].data, vecs[v].dir, vecs[v].stall_after,
                      vecs[v].stall_len, vecs[v].exp_seq, vecs[v].exp_busy, 0);

        run_frame("abort_ff", 8'hFF, 1'b0, 99, 0, 8'hFF, W + 1, 4);
        run_frame("after_abort_81", 8'h81, 1'b0, 99, 0, 8'h81, W + 1, 0);

        for (int r = 0; r < 20; r++) begin
            logic [W-1:0] d;
            logic         dr;
            int           sa, sl;
            d  = W'($urandom);
            dr = 1'($urandom);
            sa = int'($urandom_range(0, W - 1));
            sl = int'($urandom_range(0, 3));
            run_frame("rand", d, dr, sa, sl, model_seq(d, dr), W + 1 + sl, 0);
        end

        run_frame("loop_3c", 8'h3C, 1'b0, 99, 0, 8'h3C, W + 1, 0);
        @(posedge clk); @(posedge clk); #2;
        check("chk_clean", 32'(chk_err), 32'd0);

        // Corrupt the register contents during the post-frame IDLE cycle.
        run_frame("loop_bad", 8'h3C, 1'b0, 99, 0, 8'h3C, W + 1, 0);
        ovr_val = 8'h01; ovr_en = 1'b1;
        @(posedge clk); #1 ovr_en = 1'b0;
        #1 check("chk_set", 32'(chk_err), 32'(exp_err));
        run_frame("loop_after", 8'h5A, 1'b1, 99, 0, model_seq(8'h5A, 1'b1), W + 1, 0);
        @(posedge clk); #2;
        check("chk_sticky", 32'(chk_err), 32'(exp_err));
        #1 rst = 1'b1;
        #1 check("chk_rst", 32'(chk_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_tx_ctrl.md
Name: shift_tx_ctrl

Overview:
Sequencer that turns the 8-bit universal shift register into a framed serial transmitter. Accepts a parallel word on a valid/ready request port and drives the register's mode/si/din to parallel-load it. It then shifts the word out one bit per cycle, MSB-first (left) or LSB-first (right), and presents each bit on a valid/ready serial output port. Sits between a word producer and the shift register instance.

Parameters:
WIDTH, 8, word width; must match the attached shift register.
FILL, 1'b0, value driven on sr_si while shifting.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  word request valid
req_ready  out  1  controller can accept a word
req_data  in  WIDTH  word to transmit
req_dir  in  1  0 = MSB-first (left shift), 1 = LSB-first (right shift); sampled with req_data
sr_mode  out  2  to shift register: 00 hold, 01 left, 10 right, 11 load
sr_si  out  1  to shift register serial input
sr_din  out  WIDTH  to shift register parallel input
sr_q  in  WIDTH  from shift register contents
sr_so_left  in  1  from shift register, equals sr_q[WIDTH-1]
sr_so_right  in  1  from shift register, equals sr_q[0]
tx_bit  out  1  current serial bit
tx_valid  out  1  tx_bit valid
tx_ready  in  1  sink accepts tx_bit this cycle
tx_last  out  1  final bit of the word
busy  out  1  frame in progress
chk_err  out  1  sticky loopback error (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, bit counter=0, held word=0, dir=0, chk_err=0. Outputs: req_ready=1, busy=0, sr_mode=00, sr_si=FILL, sr_din=0, tx_valid=0, tx_last=0, tx_bit=0.
- The shift register's own reset is separate; the controller never relies on it.
- States:
  - IDLE: req_ready=1, sr_mode=00. On req_valid&&req_ready at an edge: capture req_data and req_dir, go to LOAD.
  - LOAD (1 cycle): sr_mode=11, sr_din=held word, req_ready=0, busy=1. Go to SHIFT.
  - SHIFT: busy=1, tx_valid=1. tx_bit = dir ? sr_so_right : sr_so_left, which is the bit about to leave the register.
    - If tx_ready: sr_mode = dir ? 10 : 01, sr_si=FILL, counter++.
    - If !tx_ready: sr_mode=00; tx_bit, counter and register contents hold.
    - tx_last=1 when counter==WIDTH-1.
    - Handshake at counter==WIDTH-1 and tx_ready: counter=0, go to IDLE.
- req_ready is 0 in LOAD and SHIFT. No back-to-back acceptance in the last SHIFT cycle.
- Minimum frame: 1 accept edge, 1 LOAD cycle, WIDTH SHIFT cycles. busy is high for WIDTH+1 cycles. Peak throughput is one word per WIDTH+2 cycles.
- tx_valid, once asserted in SHIFT, stays high until its handshake; tx_bit is stable while stalled.
- The controller treats req_data/req_dir changes outside the accept edge as don't-care.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs beyond WIDTH-1.

Optional Feature:
Macro LOOPBACK_CHECK_EN.
- Defined: on the first IDLE cycle after a completed frame, compare sr_q to {WIDTH{FILL}}. On mismatch, set chk_err=1 (sticky until rst). Frames aborted by reset are not checked.
- Undefined: chk_err is tied to 0 and no compare logic is built.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> req_ready=1, busy=0, tx_valid=0, sr_mode=00. Assert rst mid-cycle -> outputs return to reset values immediately, without waiting for clk.
- MSB-first: req_data=0x1E, req_dir=0, tx_ready=1 -> LOAD cycle shows sr_mode=11, sr_din=0x1E. Then tx_bit=0,0,0,1,1,1,1,0 on 8 consecutive cycles, sr_mode=01 on each, tx_last only on the 8th, busy high 9 cycles.
- LSB-first: req_data=0x1E, req_dir=1 -> tx_bit=0,1,1,1,1,0,0,0, sr_mode=10 on each.
- Backpressure: 0xA5, dir=0, tx_ready=0 for 3 cycles after the 2nd bit -> sr_mode=00 and tx_bit=1 held during the stall. Sequence is still 1,0,1,0,0,1,0,1; busy high 12 cycles.
- Mid-frame reset: 0xFF, rst pulse after the 4th bit -> immediate IDLE, tx_valid=0. The next request 0x81 transmits correctly as 1,0,0,0,0,0,0,1.
- LOOPBACK_CHECK_EN defined, FILL=0: normal 0x3C frame -> chk_err=0. Force sr_q=0x01 in the post-frame IDLE cycle -> chk_err=1 and stays 1 until rst.
